// File: rtl/motor_link_pkg.sv
// Shared constants, FSM state type and frame byte selection for the motor command link.
package motor_link_pkg;

  localparam int unsigned NUM_MOTORS_MAX = 10;
  localparam int unsigned FRAME_BYTES    = 5;
  localparam int unsigned DIV_W          = 15;
  localparam int unsigned STEPS_W        = 17;
  localparam int unsigned WORD_W         = DIV_W + STEPS_W;
  localparam int unsigned PART_BIT       = 7;
  localparam int unsigned FLAGS_W        = 5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBusyHi,
    StBusyLo,
    StGap
  } senderState_e;

  // Byte 0 carries the motor index, bytes 1..4 the word least-significant byte first.
  function automatic logic [7:0] frameByte(input logic [2:0]        idx,
                                           input logic [3:0]        motor,
                                           input logic [WORD_W-1:0] word);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {4'h0, motor};
      3'd1:    b = word[7:0];
      3'd2:    b = word[15:8];
      3'd3:    b = word[23:16];
      3'd4:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/motor_cmd_sender_if.sv
// Host command handshake between the sequencer (master) and the frame sender (slave).
interface motor_cmd_sender_if;
  import motor_link_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_motor;
  logic [DIV_W-1:0]   cmd_divider;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_reject;

  modport master (
    output cmd_valid, cmd_motor, cmd_divider, cmd_steps,
    input  cmd_ready, cmd_reject
  );

  modport slave (
    input  cmd_valid, cmd_motor, cmd_divider, cmd_steps,
    output cmd_ready, cmd_reject
  );

endinterface

// File: rtl/motor_status_parser.sv
// Turns CPLD status bytes into the pending vector and a one-cycle update strobe.
module motor_status_parser
  import motor_link_pkg::*;
(
  input  logic                      CLK_SE_AR,
  input  logic                      rst_n,
  input  logic                      rx_ready,
  input  logic [7:0]                rx_data,
  output logic [NUM_MOTORS_MAX-1:0] pending,
  output logic                      status_err,
  output logic                      statusValid,
  output logic                      statusPart,
  output logic [FLAGS_W-1:0]        statusFlags
);

  logic rxPrev;
  logic rxEdge;
  logic malformed;

  assign rxEdge      = rx_ready & ~rxPrev;
  assign malformed   = (rx_data[6:5] != 2'b00);
  assign statusValid = rxEdge & ~malformed;
  assign statusPart  = rx_data[PART_BIT];
  assign statusFlags = rx_data[FLAGS_W-1:0];

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      rxPrev     <= 1'b0;
      status_err <= 1'b0;
      pending    <= '0;
    end else begin
      rxPrev     <= rx_ready;
      status_err <= rxEdge & malformed;
      if (statusValid) begin
        if (statusPart) pending[2*FLAGS_W-1:FLAGS_W] <= statusFlags;
        else            pending[FLAGS_W-1:0]         <= statusFlags;
      end
    end
  end

endmodule

// File: rtl/motor_cmd_sender.sv
// Serializes host step commands into 5-byte UART frames and flow-controls them against
// the CPLD's reported slot occupancy plus the locally tracked unconfirmed commands.
module motor_cmd_sender
  import motor_link_pkg::*;
#(
  parameter int unsigned NUM_MOTORS  = 10,
  parameter int unsigned BYTE_GAP    = 16,
  parameter logic [23:0] ACK_TIMEOUT = 24'd2400000
) (
  input  logic                      CLK_SE_AR,
  input  logic                      rst_n,
  motor_cmd_sender_if.slave         cmdIf,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  input  logic                      rx_ready,
  input  logic [7:0]                rx_data,
  output logic [NUM_MOTORS_MAX-1:0] pending,
  output logic [NUM_MOTORS_MAX-1:0] inflight,
  output logic                      cmd_lost,
  output logic                      status_err
);

  localparam int unsigned      GAP_W    = $clog2(BYTE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);
  localparam logic [2:0]       LAST_IDX = 3'(FRAME_BYTES - 1);

  senderState_e              state;
  logic [2:0]                byteIdx;
  logic [GAP_W-1:0]          gapCnt;
  logic [3:0]                motorQ;
  logic [WORD_W-1:0]         wordQ;
  logic [23:0]               ackTimer [NUM_MOTORS_MAX];

  logic                      statusValid;
  logic                      statusPart;
  logic [FLAGS_W-1:0]        statusFlags;
  logic [NUM_MOTORS_MAX-1:0] confirm;
  logic [NUM_MOTORS_MAX-1:0] expire;
  logic [15:0]               slotBusy;
  logic                      motorBad;
  logic                      accept;
  logic                      frameDone;

  motor_status_parser u_parser (
    .CLK_SE_AR   (CLK_SE_AR),
    .rst_n       (rst_n),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .pending     (pending),
    .status_err  (status_err),
    .statusValid (statusValid),
    .statusPart  (statusPart),
    .statusFlags (statusFlags)
  );

  // Out-of-range motors are consumed through the reject path and never index the slots.
  assign slotBusy         = 16'(pending | inflight);
  assign motorBad         = 32'(cmdIf.cmd_motor) >= NUM_MOTORS;
  assign cmdIf.cmd_ready  = cmdIf.cmd_valid && (state == StIdle) &&
                            (motorBad || !slotBusy[cmdIf.cmd_motor]);
  assign cmdIf.cmd_reject = cmdIf.cmd_ready & motorBad;
  assign accept           = cmdIf.cmd_ready & ~motorBad;
  assign frameDone        = (state == StGap) && (gapCnt == GAP_LAST) && (byteIdx == LAST_IDX);

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      byteIdx  <= 3'd0;
      gapCnt   <= '0;
      motorQ   <= 4'd0;
      wordQ    <= '0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            motorQ   <= cmdIf.cmd_motor;
            wordQ    <= {cmdIf.cmd_steps, cmdIf.cmd_divider};
            byteIdx  <= 3'd0;
            tx_data  <= frameByte(3'd0, cmdIf.cmd_motor, '0);
            tx_start <= 1'b1;
            state    <= StLoad;
          end
        end
        StLoad:   state <= StBusyHi;
        StBusyHi: if (tx_busy) state <= StBusyLo;
        StBusyLo: begin
          if (!tx_busy) begin
            gapCnt <= '0;
            state  <= StGap;
          end
        end
        StGap: begin
          if (gapCnt != GAP_LAST) begin
            gapCnt <= gapCnt + 1'b1;
          end else if (byteIdx == LAST_IDX) begin
            state <= StIdle;
          end else begin
            byteIdx  <= byteIdx + 3'd1;
            tx_data  <= frameByte(byteIdx + 3'd1, motorQ, wordQ);
            tx_start <= 1'b1;
            state    <= StLoad;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // A status flag of 1 confirms the slot, and beats both a timeout and a same-cycle set.
  always_comb begin
    confirm = '0;
    if (statusValid) begin
      confirm = statusPart ? {statusFlags, {FLAGS_W{1'b0}}} : {{FLAGS_W{1'b0}}, statusFlags};
    end
    expire = '0;
    for (int m = 0; m < NUM_MOTORS_MAX; m++) begin
      expire[m] = inflight[m] && (ackTimer[m] == 24'd0) && !confirm[m];
    end
  end

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      cmd_lost <= 1'b0;
      for (int m = 0; m < NUM_MOTORS_MAX; m++) ackTimer[m] <= 24'd0;
    end else begin
      cmd_lost <= |expire;
      for (int m = 0; m < NUM_MOTORS_MAX; m++) begin
        if (confirm[m] || expire[m]) begin
          inflight[m] <= 1'b0;
        end else if (frameDone && (motorQ == 4'(m))) begin
          inflight[m] <= 1'b1;
          ackTimer[m] <= ACK_TIMEOUT - 24'd1;
        end else if (inflight[m] && (ackTimer[m] != 24'd0)) begin
          ackTimer[m] <= ackTimer[m] - 24'd1;
        end
      end
    end
  end

endmodule

// File: doc/motor_cmd_sender.md
Name: motor_cmd_sender

Overview:
- Host-side initiator for the motor command link: serializes per-motor step commands into 5-byte UART frames for the vertical motor CPLD.
- Parses the CPLD's returning status bytes into a 10-bit pending vector.
- Uses that vector to flow-control commands, so a command is never sent to a motor whose slot is still occupied.
- Sits between the host sequencer and a byte-wide async_transmitter/async_receiver pair.

Parameters:
- NUM_MOTORS, 10, number of motor channels (index 0..NUM_MOTORS-1).
- BYTE_GAP, 16, idle clocks inserted after each transmitted byte.
- ACK_TIMEOUT, 24'd2400000, clocks to wait for a status byte confirming a sent command before abandoning it (100 ms at 24 MHz).

Ports:
- CLK_SE_AR  in  1  system clock (24 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  host has a command.
- cmd_ready  out  1  command accepted this cycle (valid & ready).
- cmd_motor  in  4  target motor index.
- cmd_divider  in  15  step-rate divider.
- cmd_steps  in  17  steps to go.
- cmd_reject  out  1  1-cycle pulse: cmd_motor >= NUM_MOTORS; the command is consumed and not sent.
- tx_start  out  1  1-cycle start strobe to the byte transmitter.
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls.
- tx_busy  in  1  transmitter busy.
- rx_ready  in  1  receiver byte-ready (level; rising edge = new byte).
- rx_data  in  8  received byte.
- pending  out  10  last reported CPLD slot-full flags.
- inflight  out  10  sent but not yet confirmed by status.
- cmd_lost  out  1  1-cycle pulse on ACK_TIMEOUT expiry.
- status_err  out  1  1-cycle pulse on a malformed status byte.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM in IDLE; pending=0; inflight=0; timers cleared. Reset mid-frame abandons the frame immediately and sends no further bytes. Release is synchronous to CLK_SE_AR.
- Frame format:
  - byte0 = {4'h0, motor}.
  - bytes1..4 = word W = {steps[16:0], divider[14:0]}, least-significant byte first: byte1=W[7:0], byte2=W[15:8], byte3=W[23:16], byte4=W[31:24].
- cmd_ready=1 only in IDLE and only if either condition holds:
  - cmd_motor >= NUM_MOTORS (reject path), or
  - pending[m]=0 and inflight[m]=0 for m=cmd_motor.
- On accept: latch motor and W, go to LOAD. If the command is rejected, pulse cmd_reject and stay in IDLE. A blocked command waits with cmd_ready=0; the host may hold it or change it.
- FSM:
  - IDLE: waits for an acceptable command.
  - LOAD: drives tx_data from byte_idx (0..4) and pulses tx_start for one cycle. Next state BUSY_HI.
  - BUSY_HI: waits for tx_busy=1. Next state BUSY_LO.
  - BUSY_LO: waits for tx_busy=0. Next state GAP.
  - GAP: counts BYTE_GAP clocks, then either byte_idx<4 → increment byte_idx, back to LOAD; or byte_idx==4 → set inflight[m], load that motor's timeout counter, return to IDLE.
  - Latency from accept to the first tx_start is 1 clock.
- Status RX:
  - Edge detector on rx_ready; one byte is taken per rising edge.
  - Status byte = {part, 2'b00, flags[4:0]}. part=0 updates pending[4:0]; part=1 updates pending[9:5]; the update lands the cycle after the edge.
  - Bits 6:5 nonzero: byte discarded, pending unchanged, status_err pulse.
  - Only status bytes arrive on this link; no framing beyond the part bit.
- Inflight clear, evaluated per motor on each accepted status byte covering that motor:
  - If the new flag is 1, clear inflight[m]; the CPLD latched the command.
  - If the flag is 0, inflight[m] holds.
- Timeouts:
  - Each inflight motor has its own down-counter. At 0: clear inflight[m] and pulse cmd_lost. If several motors expire in the same cycle, only one cmd_lost pulse is produced.
  - A status byte and a timeout on the same motor in the same cycle: status wins, no cmd_lost.
- Simultaneous events: setting inflight[m] at frame end in the same cycle as a status byte with flag 1 for m leaves inflight[m]=0. The status byte is treated as a confirmation.
- tx_busy stuck low in BUSY_HI: no timeout; the FSM waits indefinitely. Recovery is by reset.

Decomposition:
- Package motor_link_pkg holds:
  - constants NUM_MOTORS_MAX=10, FRAME_BYTES=5, DIV_W=15, STEPS_W=17;
  - status bit positions (PART_BIT=7, FLAGS_W=5);
  - the FSM state enum.
- One sub-module, motor_status_parser: rx edge detect, format check, pending register and status_err. It exposes a one-cycle status-update strobe carrying part and flags.

Test Plan:
- Reset, then cmd motor=3, div=15'h0123, steps=17'h00045. Required response:
  - bytes sent, in order: 03, 23, 81, 22, 00;
  - exactly 5 tx_start pulses, each ≥BYTE_GAP clocks after the previous tx_busy fall;
  - inflight[3]=1 afterwards.
- Status byte 8'h08 (part 0, flag3) → pending=10'h008, inflight[3]=0. A second cmd to motor 3 then holds cmd_ready=0. Status 8'h00 → cmd_ready=1.
- cmd_motor=12 → cmd_reject pulse, no tx_start, FSM stays in IDLE.
- Status 8'h9F → pending[9:5]=5'h1F. Status 8'h20 → status_err pulse, pending unchanged.
- Send to motor 0 with no status reply → cmd_lost pulse exactly ACK_TIMEOUT clocks after frame end; inflight[0]=0.
- rst_n asserted after byte 2 of a frame → no further tx_start, all outputs 0. The next command after release starts cleanly at byte0.
